packet_splitter: RTL and testbench

//  Source-side stage that feeds packet_collector through the NoC. Accepts whole PAYLOAD-bit packets with a

---
 rtl/packet_splitter.sv | 138 +++++++++++++
 tb/tb_packet_splitter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_splitter.sv
// Source-side NoC stage: queues whole packets with a rolling ID and serialises each
// into FLIT_COUNT flits, MSB chunk first, in the packet_collector flit format.
module packet_splitter #(
  parameter int unsigned NODE_COUNT      = 8,
  parameter int unsigned PACKET_ID_WIDTH = 5,
  parameter int unsigned PAYLOAD         = 32,
  parameter int unsigned FLIT_PAYLOAD    = 8,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned NODE_ID         = 0,
  localparam int unsigned NODE_W     = $clog2(NODE_COUNT),
  localparam int unsigned ID_W       = PACKET_ID_WIDTH,
  localparam int unsigned FLIT_COUNT = (PAYLOAD + FLIT_PAYLOAD - 1) / FLIT_PAYLOAD,
  localparam int unsigned IDX_W      = (FLIT_COUNT > 1) ? $clog2(FLIT_COUNT) : 1,
  localparam int unsigned FLIT_W     = 1 + 2 * NODE_W + FLIT_PAYLOAD + ID_W + IDX_W,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                valid_in,
  output logic                ready_out,
  input  logic [PAYLOAD-1:0]  packet_in,
  input  logic [NODE_W-1:0]   node_dest_in,
  output logic [ID_W-1:0]     packet_id_out,
  output logic                flit_valid,
  input  logic                flit_ready,
  output logic [FLIT_W-1:0]   flit_out,
  output logic                busy,
  output logic [CNT_W-1:0]    fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PAD_W = FLIT_COUNT * FLIT_PAYLOAD;

  typedef struct packed {
    logic [PAYLOAD-1:0] data;
    logic [NODE_W-1:0]  dest;
    logic [ID_W-1:0]    id;
  } entry_t;

  typedef enum logic {IDLE, SEND} state_t;

  entry_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ID_W-1:0]    id_q;
  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [PAD_W-1:0]   sh_q;
  logic [NODE_W-1:0]  dest_q;
  logic [ID_W-1:0]    pid_q;

  logic   full_c, empty_c, push_c, pop_c, xfer_c, last_c;
  entry_t head_c;

  assign full_c  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_c = (count_q == '0);
  assign push_c  = ce && valid_in && !full_c;
  assign xfer_c  = ce && (state_q == SEND) && flit_ready;
  assign last_c  = (idx_q == IDX_W'(FLIT_COUNT - 1));
  assign head_c  = mem_q[rd_ptr_q];

  // Pop when idle, or on the last flit's transfer so packets go out without a bubble
  always_comb begin
    pop_c = 1'b0;
    case (state_q)
      IDLE:    pop_c = ce && !empty_c;
      SEND:    pop_c = xfer_c && last_c && !empty_c;
      default: pop_c = 1'b0;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= '{data: packet_in, dest: node_dest_in, id: id_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      id_q     <= '0;
    end else begin
      count_q <= count_d;
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        id_q     <= id_q + ID_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Serialiser: the head packet is left-aligned so the top chunk is always the current flit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
      dest_q  <= '0;
      pid_q   <= '0;
    end else begin
      if (pop_c) begin
        state_q <= SEND;
        idx_q   <= '0;
        sh_q    <= PAD_W'(head_c.data) << (PAD_W - PAYLOAD);
        dest_q  <= head_c.dest;
        pid_q   <= head_c.id;
      end else if (xfer_c) begin
        if (last_c) begin
          state_q <= IDLE;
          idx_q   <= '0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
          sh_q  <= sh_q << FLIT_PAYLOAD;
        end
      end
    end
  end

  assign ready_out     = !full_c;
  assign packet_id_out = id_q;
  assign fifo_count    = count_q;
  assign flit_valid    = (state_q == SEND);
  assign busy          = (state_q == SEND) || !empty_c;
  assign flit_out      = flit_valid ?
                         {1'b1, dest_q, sh_q[PAD_W-1 -: FLIT_PAYLOAD], pid_q, NODE_W'(NODE_ID), idx_q} :
                         '0;

endmodule

// File: tb/tb_packet_splitter.sv
// Bench for packet_splitter: queue-based packet model checked every cycle, plus directed literal checks.
module tb_packet_splitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [31:0] packet_in = '0;
  logic [2:0]  node_dest_in = '0;
  logic [4:0]  packet_id_out;
  logic        flit_valid;
  logic        flit_ready = 1'b1;
  logic [21:0] flit_out;
  logic        busy;
  logic [2:0]  fifo_count;

  packet_splitter dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .valid_in(valid_in), .ready_out(ready_out),
    .packet_in(packet_in), .node_dest_in(node_dest_in), .packet_id_out(packet_id_out),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_out(flit_out),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of waiting packets and the one currently being sent
  typedef struct {
    logic [31:0] data;
    logic [2:0]  dest;
    logic [4:0]  id;
  } pkt_t;

  pkt_t mq[$];
  pkt_t cur;
  bit   active = 1'b0;
  int   idx = 0;
  int   idc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      active = 1'b0;
      idx = 0;
      idc = 0;
    end else begin : upd
      bit   push, xfer, pop;
      pkt_t nw;
      push = ce && valid_in && (mq.size() < 4);
      xfer = ce && active && flit_ready;
      pop  = ce && (mq.size() > 0) && (!active || (xfer && idx == 3));
      nw.data = packet_in;
      nw.dest = node_dest_in;
      nw.id   = 5'(idc);
      if (pop) begin
        cur = mq.pop_front();
        active = 1'b1;
        idx = 0;
      end else if (xfer) begin
        if (idx == 3) active = 1'b0;
        else idx++;
      end
      if (push) begin
        mq.push_back(nw);
        idc = (idc + 1) % 32;
      end
    end
  end

  function automatic logic [21:0] exp_flit();
    logic [7:0] ch;
    if (!active) return '0;
    ch = 8'(cur.data >> (32 - 8 * (idx + 1)));
    return {1'b1, cur.dest, ch, cur.id, 3'd0, 2'(idx)};
  endfunction

  always @(negedge clk) begin
    chk("flit_valid", 64'(flit_valid), 64'(active));
    chk("flit_out", 64'(flit_out), 64'(exp_flit()));
    chk("ready_out", 64'(ready_out), 64'(mq.size() < 4));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("busy", 64'(busy), 64'(active || mq.size() > 0));
    chk("packet_id_out", 64'(packet_id_out), 64'(idc));
  end

  logic [31:0] d2 [6];
  logic [2:0]  n2 [6];

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flit_valid", 64'(flit_valid), 64'd0);
    chk("rst_flit_out", 64'(flit_out), 64'd0);
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_id", 64'(packet_id_out), 64'd0);

    // Single packet, byte order and field placement
    valid_in = 1'b1;
    packet_in = 32'hA1B2C3D4;
    node_dest_in = 3'd3;
    step();
    valid_in = 1'b0;
    chk("t1_id_after_push", 64'(packet_id_out), 64'd1);
    chk("t1_count", 64'(fifo_count), 64'd1);
    chk("t1_no_flit_yet", 64'(flit_valid), 64'd0);
    step();
    chk("t1_flit0", 64'(flit_out), 64'({1'b1, 3'd3, 8'hA1, 5'd0, 3'd0, 2'd0}));
    step();
    chk("t1_flit1", 64'(flit_out), 64'({1'b1, 3'd3, 8'hB2, 5'd0, 3'd0, 2'd1}));
    step();
    chk("t1_flit2", 64'(flit_out), 64'({1'b1, 3'd3, 8'hC3, 5'd0, 3'd0, 2'd2}));
    step();
    chk("t1_flit3", 64'(flit_out), 64'({1'b1, 3'd3, 8'hD4, 5'd0, 3'd0, 2'd3}));
    step();
    chk("t1_idle", 64'(flit_valid), 64'd0);
    chk("t1_not_busy", 64'(busy), 64'd0);

    // Fill while stalled: 5 accepted, 6th refused
    flit_ready = 1'b0;
    valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d2[i] = $urandom;
      n2[i] = 3'($urandom);
      packet_in = d2[i];
      node_dest_in = n2[i];
      step();
    end
    valid_in = 1'b0;
    chk("t2_ready_low", 64'(ready_out), 64'd0);
    chk("t2_count_full", 64'(fifo_count), 64'd4);
    chk("t2_id_no_waste", 64'(packet_id_out), 64'd6);

    // Stall pattern 1,0,0,1 mid-packet
    flit_ready = 1'b1;
    step();
    flit_ready = 1'b0;
    step();
    step();
    chk("t4_stalled", 64'(flit_out), 64'({1'b1, n2[0], d2[0][23:16], 5'd1, 3'd0, 2'd1}));
    flit_ready = 1'b1;
    step();
    chk("t4_resumed", 64'(flit_out), 64'({1'b1, n2[0], d2[0][15:8], 5'd1, 3'd0, 2'd2}));
    repeat (24) step();
    chk("t3_drained", 64'(busy), 64'd0);

    // Reset during flit 2 discards everything
    valid_in = 1'b1;
    packet_in = $urandom;
    step();
    packet_in = $urandom;
    step();
    valid_in = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_flit_valid", 64'(flit_valid), 64'd0);
    chk("t6_count", 64'(fifo_count), 64'd0);
    step();
    rst_n = 1'b1;

    // 33 pushes, IDs wrap after 31
    valid_in = 1'b1;
    for (int n = 0; n < 33; n++) begin
      int w;
      w = 0;
      packet_in = $urandom;
      node_dest_in = 3'($urandom);
      while (!ready_out && w < 50) begin
        step();
        w++;
      end
      if (w >= 50) chk("t5_timeout", 64'd1, 64'd0);
      chk("t5_wrap_id", 64'(packet_id_out), 64'(n % 32));
      step();
    end
    valid_in = 1'b0;
    repeat (30) step();

    // Random traffic, ce and backpressure
    for (int c = 0; c < 1500; c++) begin
      valid_in = ($urandom_range(0, 1) == 1);
      packet_in = $urandom;
      node_dest_in = 3'($urandom);
      flit_ready = ($urandom_range(0, 9) < 7);
      ce = ($urandom_range(0, 9) != 0);
      step();
    end
    valid_in = 1'b0;
    ce = 1'b1;
    flit_ready = 1'b1;
    repeat (40) step();
    chk("final_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
